// File: rtl/cache_pkg.sv
// Shared definitions for the shared-port cache request logic: FSM state
// encoding and the round-robin pick used by every requester arbiter.
package cache_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int MAX_REQ    = 8;
    localparam int IDX_W      = $clog2(MAX_REQ);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid, searching upward from ptr+1 and wrapping at num.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [IDX_W-1:0]   ptr,
                                         input logic [IDX_W:0]     num);
        rr_pick_t         r;
        logic [IDX_W:0]   cand;
        r = '0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            cand = (IDX_W+1)'((int'(ptr) + i) % int'(num));
            if (i <= int'(num) && !r.found && valid[cand[IDX_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = cand[IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant from the request vector and a
// pointer that only moves when the owner signals completion.
module rr_arbiter
    import cache_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic               i_upd,
    input  logic [IDX_W-1:0]   i_upd_idx,
    output logic               o_found,
    output logic [IDX_W-1:0]   o_gnt_idx
);

    logic [IDX_W-1:0]   r_ptr;
    logic [MAX_REQ-1:0] w_valid;
    rr_pick_t           w_pick;

    assign w_valid   = MAX_REQ'(i_valid);
    assign w_pick    = rr_pick(w_valid, r_ptr, (IDX_W+1)'(NUM_REQ));
    assign o_found   = w_pick.found;
    assign o_gnt_idx = w_pick.idx;

    // Pointer starts at the last requester so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= IDX_W'(NUM_REQ - 1);
        end else if (i_upd) begin
            r_ptr <= i_upd_idx;
        end
    end

endmodule

// File: rtl/cache_req_arbiter.sv
// Shares one single-port cache among NUM_REQ requesters, one access in
// flight at a time, with saturating read hit/miss counters.
module cache_req_arbiter
    import cache_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int CACHE_LAT = 1,
    parameter int CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_hit,
    output logic                      c_read_en,
    output logic                      c_write_en,
    output logic [ADDR_W-1:0]         c_address,
    output logic [DATA_W-1:0]         c_write_data,
    input  logic [DATA_W-1:0]         c_read_data,
    input  logic                      c_hit,
    output logic [CNT_W-1:0]          hit_cnt,
    output logic [CNT_W-1:0]          miss_cnt
);

    localparam int LAT_W = $clog2(CACHE_LAT + 1);

    arb_state_t         r_state, w_next;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_write;
    logic [IDX_W-1:0]   r_gnt;
    logic [LAT_W-1:0]   r_lat;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_hit;
    logic [CNT_W-1:0]   r_hit_cnt;
    logic [CNT_W-1:0]   r_miss_cnt;

    logic               w_found;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic [NUM_REQ-1:0] w_gnt_oh;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;
    logic               w_sel_write;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (req_valid),
        .i_upd     (r_state == RESP),
        .i_upd_idx (r_gnt),
        .o_found   (w_found),
        .o_gnt_idx (w_gnt_idx)
    );

    always_comb begin
        w_gnt_oh    = '0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_write = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_found && w_gnt_idx == IDX_W'(i)) begin
                w_gnt_oh[i] = 1'b1;
                w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                w_sel_write = req_write[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_found) w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT:    if (r_lat == LAT_W'(1)) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // req_ready is gated by rst so every output reads 0 while reset is held.
    always_comb begin
        req_ready  = '0;
        rsp_valid  = '0;
        c_read_en  = 1'b0;
        c_write_en = 1'b0;
        case (r_state)
            IDLE:  if (!rst) req_ready = w_gnt_oh;
            ISSUE: begin
                c_read_en  = !r_write;
                c_write_en = r_write;
            end
            RESP: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    rsp_valid[i] = (r_gnt == IDX_W'(i));
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_write    <= 1'b0;
            r_gnt      <= '0;
            r_lat      <= '0;
            r_rdata    <= '0;
            r_hit      <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_found) begin
                    r_addr  <= w_sel_addr;
                    r_wdata <= w_sel_wdata;
                    r_write <= w_sel_write;
                    r_gnt   <= w_gnt_idx;
                end
                ISSUE: r_lat <= LAT_W'(CACHE_LAT);
                WAIT: begin
                    r_lat <= r_lat - 1'b1;
                    if (r_lat == LAT_W'(1)) begin
                        r_rdata <= r_write ? '0 : c_read_data;
                        r_hit   <= c_hit;
                    end
                end
                RESP: if (!r_write) begin
                    if (r_hit) r_hit_cnt  <= sat_inc(r_hit_cnt);
                    else       r_miss_cnt <= sat_inc(r_miss_cnt);
                end
                default: ;
            endcase
        end
    end

    assign c_address    = r_addr;
    assign c_write_data = r_wdata;
    assign rsp_rdata    = r_rdata;
    assign rsp_hit      = r_hit;
    assign hit_cnt      = r_hit_cnt;
    assign miss_cnt     = r_miss_cnt;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter with a small one-cycle cache model.
module tb_cache_req_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_write, req_ready, rsp_valid;
    logic [15:0] req_addr, req_wdata;
    logic [7:0]  rsp_rdata, c_address, c_write_data, c_read_data;
    logic        rsp_hit, c_read_en, c_write_en, c_hit;
    logic [3:0]  hit_cnt, miss_cnt;

    logic [7:0]  mem [256];
    logic        vld [256];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cache_req_arbiter #(
        .NUM_REQ(2), .ADDR_W(8), .DATA_W(8), .CACHE_LAT(1), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_hit(rsp_hit),
        .c_read_en(c_read_en), .c_write_en(c_write_en),
        .c_address(c_address), .c_write_data(c_write_data),
        .c_read_data(c_read_data), .c_hit(c_hit),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // Cache model: result valid one cycle after the enable edge.
    always @(posedge clk) begin
        if (c_write_en) begin
            mem[c_address] <= c_write_data;
            vld[c_address] <= 1'b1;
            c_hit          <= 1'b1;
        end else if (c_read_en) begin
            c_read_data <= mem[c_address];
            c_hit       <= vld[c_address];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input bit v, input bit w,
                           input logic [7:0] a, input logic [7:0] d);
        req_valid[r]        = v;
        req_write[r]        = w;
        req_addr[r*8 +: 8]  = a;
        req_wdata[r*8 +: 8] = d;
    endtask

    task automatic wait_rsp(input string tag, input int r,
                            output logic [7:0] rd, output logic h);
        bit got = 0;
        rd = '0;
        h  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid[r]) begin
                rd  = rsp_rdata;
                h   = rsp_hit;
                got = 1;
                break;
            end
        end
        chk({tag, "_rsp_seen"}, 64'(got), 64'd1);
    endtask

    task automatic do_xact(input string tag, input int r, input bit w,
                           input logic [7:0] a, input logic [7:0] d,
                           output logic [7:0] rd, output logic h);
        bit acc = 0;
        @(posedge clk); #1;
        set_req(r, 1'b1, w, a, d);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (req_ready[r]) begin
                acc = 1;
                break;
            end
        end
        chk({tag, "_accept"}, 64'(acc), 64'd1);
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
        wait_rsp(tag, r, rd, h);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [7:0] rd;
    logic       h;
    logic [1:0] order [6];
    int         gcyc  [6];
    int         n;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h00;
            vld[i] = 1'b0;
        end
        c_read_data = '0;
        c_hit       = 1'b0;
        req_valid   = '0;
        req_write   = '0;
        req_addr    = '0;
        req_wdata   = '0;
        rst         = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_outputs",
            64'({req_ready, rsp_valid, rsp_rdata, rsp_hit, c_read_en, c_write_en,
                 c_address, c_write_data, hit_cnt, miss_cnt}), 64'd0);
        rst = 1'b0;

        // Test 1: write then read back
        do_xact("t1_wr", 0, 1'b1, 8'h10, 8'hAA, rd, h);
        chk("t1_wr_rdata", 64'(rd), 64'h00);
        do_xact("t1_rd", 0, 1'b0, 8'h10, 8'h00, rd, h);
        chk("t1_rd_rdata", 64'(rd), 64'hAA);
        chk("t1_rd_hit", 64'(h), 64'd1);
        @(negedge clk);
        chk("t1_cnts", 64'({hit_cnt, miss_cnt}), 64'h10);

        // Test 2: cycle-exact timing
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
        @(negedge clk);
        chk("t2_ready_t", 64'(req_ready), 64'd1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("t2_rden", 64'(c_read_en), 64'(k == 1));
            chk("t2_wren", 64'(c_write_en), 64'd0);
            chk("t2_ready_low", 64'(req_ready), 64'd0);
            chk("t2_rsp_valid", 64'(rsp_valid), (k == 3) ? 64'd1 : 64'd0);
            if (k == 1) begin
                chk("t2_addr", 64'(c_address), 64'h10);
                req_valid[0] = 1'b0;
            end
        end

        // Test 3: simultaneous requests right after reset
        pulse_rst();
        set_req(0, 1'b1, 1'b0, 8'h30, 8'h00);
        set_req(1, 1'b1, 1'b1, 8'h30, 8'hBB);
        #1;
        chk("t3_first_grant", 64'(req_ready), 64'b01);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_rsp("t3_rd0", 0, rd, h);
        chk("t3_rd0_hit", 64'(h), 64'd0);
        @(negedge clk);
        chk("t3_second_grant", 64'(req_ready), 64'b10);
        chk("t3_miss_cnt", 64'(miss_cnt), 64'd1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_rsp("t3_wr1", 1, rd, h);
        chk("t3_wr1_rdata", 64'(rd), 64'h00);
        do_xact("t3_rd1", 1, 1'b0, 8'h30, 8'h00, rd, h);
        chk("t3_rd1_rdata", 64'(rd), 64'hBB);
        chk("t3_rd1_hit", 64'(h), 64'd1);

        // Test 4: fairness with both requesters held valid
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
        set_req(1, 1'b1, 1'b0, 8'h30, 8'h00);
        n = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                order[n] = req_ready;
                gcyc[n]  = c;
                n++;
            end
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        chk("t4_grants", 64'(n), 64'd6);
        for (int i = 0; i < n; i++) begin
            chk("t4_order", 64'(order[i]), (i % 2 == 0) ? 64'b01 : 64'b10);
            if (i > 0) chk("t4_spacing", 64'(gcyc[i] - gcyc[i-1]), 64'd4);
        end
        repeat (4) @(negedge clk);

        // Test 5: reset during WAIT of a req1 read
        @(posedge clk); #1;
        set_req(1, 1'b1, 1'b0, 8'h10, 8'h00);
        @(negedge clk);
        chk("t5_grant1", 64'(req_ready), 64'b10);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
        set_req(1, 1'b1, 1'b0, 8'h30, 8'h00);
        rst = 1'b1;
        #1;
        chk("t5_reset_outputs",
            64'({req_ready, rsp_valid, rsp_rdata, rsp_hit, c_read_en, c_write_en,
                 c_address, c_write_data, hit_cnt, miss_cnt}), 64'd0);
        @(negedge clk);
        chk("t5_no_rsp", 64'(rsp_valid), 64'd0);
        rst = 1'b0;
        #1;
        chk("t5_first_grant", 64'(req_ready), 64'b01);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_rsp("t5_rd0", 0, rd, h);
        chk("t5_rd0_rdata", 64'(rd), 64'hAA);
        @(negedge clk);
        chk("t5_second_grant", 64'(req_ready), 64'b10);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_rsp("t5_rd1", 1, rd, h);
        chk("t5_rd1_rdata", 64'(rd), 64'hBB);

        // Test 6: counter saturation at 4 bits
        pulse_rst();
        do_xact("t6_wr", 0, 1'b1, 8'h40, 8'h55, rd, h);
        @(negedge clk);
        chk("t6_cnts_after_wr", 64'({hit_cnt, miss_cnt}), 64'h00);
        for (int k = 1; k <= 17; k++) begin
            do_xact("t6_rd", 0, 1'b0, 8'h40, 8'h00, rd, h);
            if (k == 1) chk("t6_rdata", 64'(rd), 64'h55);
            @(negedge clk);
            if (k == 1 || k >= 14) chk("t6_hit_cnt", 64'(hit_cnt), 64'((k > 15) ? 15 : k));
        end
        chk("t6_miss_cnt", 64'(miss_cnt), 64'd0);
        do_xact("t6_wr2", 1, 1'b1, 8'h41, 8'h66, rd, h);
        @(negedge clk);
        chk("t6_cnts_after_wr2", 64'({hit_cnt, miss_cnt}), 64'hF0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
